// File: rtl/cpu5_dmem_resp.sv
// Single-port data memory with a valid/ready request and response handshake.
// Define CPU5_DMEM_WAITSTATE_EN to insert WAIT_CYCLES wait states per access.
module cpu5_dmem_resp #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

`ifdef CPU5_DMEM_WAITSTATE_EN
    localparam int W  = WAIT_CYCLES;
    localparam int CW = (W < 2) ? 1 : $clog2(W + 1);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;
`else
    // WAIT_CYCLES has no effect without wait states
    localparam int W = 0 * WAIT_CYCLES;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RESP = 2'd2
    } state_t;
`endif

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;
    logic        r_err;
    logic        w_commit;
    logic        w_op_we;
    logic [31:0] w_op_addr;
    logic [31:0] w_op_wdata;
    logic [3:0]  w_op_be;
    logic [31:0] w_hi;
    logic        w_op_err;
    logic [DEPTH_LOG2-1:0] w_idx;

`ifdef CPU5_DMEM_WAITSTATE_EN
    logic [CW-1:0] r_cnt;
    logic          r_we;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [3:0]    r_be;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else if (req_valid && req_ready) begin
            r_cnt   <= CW'(W);
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // Zero-wait accesses commit on the accepting edge, before the latch
    assign w_op_we    = (r_state == S_IDLE) ? req_we    : r_we;
    assign w_op_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
    assign w_op_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
    assign w_op_be    = (r_state == S_IDLE) ? req_be    : r_be;
`else
    // Every access completes on its accepting edge; the response
    // registers hold everything the initiator needs afterwards
    assign w_op_we    = req_we;
    assign w_op_addr  = req_addr;
    assign w_op_wdata = req_wdata;
    assign w_op_be    = req_be;
`endif

    assign w_hi     = {2'b00, w_op_addr[31:2]} >> DEPTH_LOG2;
    assign w_op_err = (w_op_addr[1:0] != 2'b00) || (w_hi != 32'd0);
    assign w_idx    = w_op_addr[DEPTH_LOG2+1:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        w_commit   = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (W == 0) begin
                        w_next   = S_RESP;
                        w_commit = 1'b1;
                    end
`ifdef CPU5_DMEM_WAITSTATE_EN
                    else begin
                        w_next = S_WAIT;
                    end
`endif
                end
            end
`ifdef CPU5_DMEM_WAITSTATE_EN
            S_WAIT: begin
                if (r_cnt == CW'(1)) begin
                    w_next   = S_RESP;
                    w_commit = 1'b1;
                end
            end
`endif
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_commit) begin
            r_err   <= w_op_err;
            r_rdata <= (w_op_err || w_op_we) ? 32'd0 : r_mem[w_idx];
        end
    end

    // Array is never reset; reset only blocks the write
    always_ff @(posedge clk) begin
        if (!reset && w_commit && !w_op_err && w_op_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_op_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_op_wdata[8*i +: 8];
                end
            end
        end
    end

    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule

// File: tb/tb_cpu5_dmem_resp.sv
// Randomised bench for cpu5_dmem_resp against a word-array memory model.
// Honours CPU5_DMEM_WAITSTATE_EN the same way the design does.
module tb_cpu5_dmem_resp;

    localparam int DL    = 10;
    localparam int DEPTH = 1 << DL;
`ifdef CPU5_DMEM_WAITSTATE_EN
    localparam int W = 2;
`else
    localparam int W = 0;
`endif

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic        req_valid  = 1'b0;
    logic        req_we     = 1'b0;
    logic [31:0] req_addr   = 32'd0;
    logic [31:0] req_wdata  = 32'd0;
    logic [3:0]  req_be     = 4'd0;
    logic        resp_ready = 1'b0;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;

    cpu5_dmem_resp #(
        .DEPTH_LOG2 (DL),
        .WAIT_CYCLES(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mdl [DEPTH];
    bit          chk_on    = 1'b0;
    logic        exp_ready = 1'b1;
    logic        exp_valid = 1'b0;
    logic        exp_err   = 1'b0;
    logic [31:0] exp_rdata = 32'd0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("resp_valid", 32'(resp_valid), 32'(exp_valid));
            if (exp_valid) begin
                chk("resp_rdata", resp_rdata, exp_rdata);
                chk("resp_err", 32'(resp_err), 32'(exp_err));
            end
        end
    end

    function automatic void model(input bit we, input logic [31:0] a,
                                  input logic [31:0] wd,
                                  input logic [3:0] be, input bit commit,
                                  output logic err,
                                  output logic [31:0] rd);
        err = (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
        rd  = 32'd0;
        if (!err) begin
            if (we) begin
                if (commit) begin
                    for (int i = 0; i < 4; i++) begin
                        if (be[i]) mdl[a >> 2][8*i +: 8] = wd[8*i +: 8];
                    end
                end
            end else begin
                rd = mdl[a >> 2];
            end
        end
    endfunction

    task automatic junk();
        req_valid = 1'($urandom_range(0, 1));
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = $urandom & 32'h0000_00FC;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
    endtask

    // mode 0: normal, 1: reset in first WAIT cycle, 2: reset in RESP
    task automatic xact(input bit we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be,
                        input int bp, input int mode,
                        output logic [31:0] g_rd, output logic g_err);
        logic        e;
        logic [31:0] rd;
        model(we, a, wd, be, (mode != 1), e, rd);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = a;
        req_wdata  = wd;
        req_be     = be;
        resp_ready = 1'($urandom_range(0, 1));
        exp_ready  = 1'b1;
        exp_valid  = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < W; i++) begin
            junk();
            resp_ready = 1'($urandom_range(0, 1));
            exp_ready  = 1'b0;
            exp_valid  = 1'b0;
            if (mode == 1) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset      = 1'b0;
                req_valid  = 1'b0;
                resp_ready = 1'b0;
                exp_ready  = 1'b1;
                g_rd       = 32'd0;
                g_err      = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        exp_valid  = 1'b1;
        exp_ready  = 1'b0;
        exp_rdata  = rd;
        exp_err    = e;
        g_rd       = resp_rdata;
        g_err      = resp_err;
        resp_ready = 1'b0;
        for (int i = 0; i < bp; i++) begin
            junk();
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        if (mode == 2) begin
            reset = 1'b1;
            @(posedge clk); #1;
            reset     = 1'b0;
            exp_valid = 1'b0;
            exp_ready = 1'b1;
            return;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        exp_valid  = 1'b0;
        exp_ready  = 1'b1;
    endtask

    logic [31:0] rd;
    logic        er;
    logic [31:0] a;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk_on = 1'b1;

        for (int i = 0; i <= 16; i++) begin
            xact(1'b1, 32'(i * 4),
                 (i == 0) ? 32'h600D_F00D : ((i == 16) ? 32'd0 : $urandom),
                 4'hF, 0, 0, rd, er);
        end

        xact(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, rd, er);
        chk("st_rdata", rd, 32'd0);
        xact(1'b0, 32'h10, 32'h0, 4'h0, 0, 0, rd, er);
        chk("ld_rdata", rd, 32'hDEAD_BEEF);
        chk("ld_err", 32'(er), 32'd0);

        xact(1'b1, 32'h20, 32'h1122_3344, 4'hF, 1, 0, rd, er);
        xact(1'b1, 32'h20, 32'hAABB_CCDD, 4'h5, 0, 0, rd, er);
        xact(1'b0, 32'h20, 32'h0, 4'h0, 0, 0, rd, er);
        chk("partial", rd, 32'h11BB_33DD);
        xact(1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0, 0, 0, rd, er);
        xact(1'b0, 32'h20, 32'h0, 4'h0, 0, 0, rd, er);
        chk("be0", rd, 32'h11BB_33DD);

        xact(1'b0, 32'h13, 32'h0, 4'h0, 0, 0, rd, er);
        chk("misal_err", 32'(er), 32'd1);
        chk("misal_rdata", rd, 32'd0);
        xact(1'b1, 32'h11, 32'h0, 4'hF, 0, 0, rd, er);
        xact(1'b0, 32'h10, 32'h0, 4'h0, 0, 0, rd, er);
        chk("misal_nowrite", rd, 32'hDEAD_BEEF);

        xact(1'b1, 32'h1000, 32'h1234_5678, 4'hF, 0, 0, rd, er);
        chk("oor_err", 32'(er), 32'd1);
        xact(1'b0, 32'h0, 32'h0, 4'h0, 0, 0, rd, er);
        chk("oor_word0", rd, 32'h600D_F00D);

        xact(1'b1, 32'h30, 32'hCAFE_F00D, 4'hF, 0, 0, rd, er);
        xact(1'b0, 32'h30, 32'h0, 4'h0, 5, 0, rd, er);
        chk("bp_rdata", rd, 32'hCAFE_F00D);

        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h40;
        req_wdata = 32'h5;
        req_be    = 4'hF;
        reset     = 1'b1;
        @(posedge clk); #1;
        reset     = 1'b0;
        req_valid = 1'b0;
        chk("rstpri_ready", 32'(req_ready), 32'd1);
        xact(1'b0, 32'h40, 32'h0, 4'h0, 0, 0, rd, er);
        chk("rstpri_word", rd, 32'd0);

        if (W > 0) begin
            xact(1'b1, 32'h40, 32'h5, 4'hF, 0, 1, rd, er);
            chk("rstwait_valid", 32'(resp_valid), 32'd0);
            chk("rstwait_ready", 32'(req_ready), 32'd1);
            xact(1'b0, 32'h40, 32'h0, 4'h0, 0, 0, rd, er);
            chk("rstwait_word", rd, 32'd0);
        end

        xact(1'b1, 32'h14, 32'h1234_5678, 4'hF, 2, 2, rd, er);
        chk("rstresp_valid", 32'(resp_valid), 32'd0);
        xact(1'b0, 32'h14, 32'h0, 4'h0, 0, 0, rd, er);
        chk("rstresp_word", rd, 32'h1234_5678);

        for (int n = 0; n < 300; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 8) a = 32'($urandom_range(0, 15) * 4);
            else if (r == 8) a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
            else a = 32'h1000 | ($urandom & 32'hFFFF_FFFC);
            xact(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom),
                 int'($urandom_range(0, 3)), 0, rd, er);
            repeat ($urandom_range(0, 2)) begin
                req_valid  = 1'b0;
                resp_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            resp_ready = 1'b0;
        end

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule

// File: doc/cpu5_dmem_resp.md
CPU5_DMEM_RESP -- requirements
Module: cpu5_dmem_resp

Interface
REQ-001 Parameter DEPTH_LOG2, default 10: memory holds 2**DEPTH_LOG2 words of 32 bits.
REQ-002 Parameter WAIT_CYCLES, default 2: wait states inserted before each response; only honoured when CPU5_DMEM_WAITSTATE_EN is defined.
REQ-003 Single clock; reset SHALL be synchronous and active-high.
REQ-004 Port list SHALL be as follows:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder accepts a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_be  input  4  byte enables for stores; bit i enables byte lane i (bits 8i+7:8i).
- resp_valid  output  1  response available.
- resp_ready  input  1  initiator accepts the response.
- resp_rdata  output  32  load data; 0 for stores and for errored requests.
- resp_err  output  1  request was misaligned or out of range.

Function
REQ-005 FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-006 IDLE behaviour:
- req_ready=1; all other cycles req_ready=0.
- A request is accepted when req_valid and req_ready are both 1 in the same cycle.
- On acceptance, latch we, addr, wdata and be.
- Next state is WAIT if the effective wait count is nonzero, otherwise RESP.
REQ-007 WAIT behaviour:
- The counter loads the wait count at acceptance and decrements by 1 each cycle.
- The FSM moves to RESP in the cycle the counter reads 1.
REQ-008 Latency: a request accepted at cycle t SHALL assert resp_valid at cycle t+1+W, where W is the effective wait count.
REQ-009 Error condition: err = (addr[1:0]!=0) OR (addr[31:2] >= 2**DEPTH_LOG2). It is evaluated on the latched address.
REQ-010 Store commit:
- A non-errored store writes only the enabled byte lanes.
- The write happens on the edge that enters RESP.
- A store with be=0 completes normally and changes no data.
REQ-011 Load data: a non-errored load captures mem[addr[DEPTH_LOG2+1:2]] into resp_rdata on the edge that enters RESP.
REQ-012 An errored request SHALL perform no write, return resp_rdata=0 and assert resp_err=1.
REQ-013 RESP behaviour:
- resp_valid=1.
- resp_rdata and resp_err are held stable while resp_ready=0 (backpressure of any length).
- When resp_ready=1, go to IDLE; resp_valid=0 in the following cycle.
REQ-014 Requests are not pipelined: the minimum request-to-request interval is 2+W cycles.
REQ-015 req_valid while req_ready=0 SHALL be ignored; the initiator holds it.
REQ-016 resp_ready while resp_valid=0 SHALL have no effect.

Reset
REQ-017 Reset SHALL set the following values:
- FSM = IDLE.
- req_ready=1 in the first cycle after reset.
- resp_valid=0, resp_err=0, resp_rdata=0.
- Wait counter = 0.
REQ-018 Memory array contents SHALL NOT be reset.
REQ-019 Reset asserted in WAIT SHALL abandon the request with no write performed.
REQ-020 Reset asserted in RESP SHALL drop the pending response; an already committed store remains in memory.
REQ-021 Reset has priority over every handshake in the same cycle.

Configuration
REQ-022 Macro CPU5_DMEM_WAITSTATE_EN SHALL control wait states:
- Defined: effective wait count W = WAIT_CYCLES; WAIT_CYCLES=0 skips WAIT.
- Undefined: W = 0, WAIT state and counter are not generated, and the response arrives at t+1.

Verification
REQ-023 Store then load:
- Stimulus: store addr=0x10, wdata=0xDEADBEEF, be=0xF; then load addr=0x10.
- Response: resp_rdata=0xDEADBEEF, resp_err=0.
- Latency: t+3 with the macro defined and WAIT_CYCLES=2; t+1 with the macro undefined.
REQ-024 Partial write:
- Stimulus: word at 0x20 holds 0x11223344; store wdata=0xAABBCCDD, be=0x5; then load 0x20.
- Response: 0x11BB33DD.
REQ-025 Misaligned access:
- Stimulus: load addr=0x13.
- Response: resp_err=1, resp_rdata=0; memory unchanged.
REQ-026 Out of range:
- Stimulus: DEPTH_LOG2=10, store addr=0x1000.
- Response: resp_err=1; reading back word 0 is unchanged.
REQ-027 Backpressure:
- Stimulus: hold resp_ready=0 for 5 cycles on a load returning 0xCAFEF00D.
- Response: resp_valid=1 and rdata=0xCAFEF00D stable all 5 cycles; req_ready=0 throughout; IDLE one cycle after resp_ready=1.
REQ-028 Reset mid-operation:
- Stimulus: assert reset during WAIT of store wdata=0x5 to 0x40 (word previously 0x0).
- Response: resp_valid=0 and req_ready=1 the cycle after reset; a subsequent load of 0x40 returns 0x0.
